// File: rtl/align_shift_pipe.sv
// Pipelined right shifter for FP significand alignment and normalisation.
// One log-shift level per register stage, with sticky, fill, tag and valid/ready.
module align_shift_pipe #(
  parameter int WIDTH = 49,
  parameter int TAG_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in,
  input  logic [$clog2(WIDTH)-1:0] nshift,
  input  logic                     arith,
  input  logic [TAG_W-1:0]         tag_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out,
  output logic                     sticky,
  output logic [TAG_W-1:0]         tag_out,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] data_a [SHW];
  logic [SHW-1:0]   sh_a   [SHW];
  logic [TAG_W-1:0] tag_a  [SHW];
  logic             fill_a [SHW];
  logic             stk_a  [SHW];
  logic             v_a    [SHW];
  logic [SHW:0]     rdy;

  assign rdy[SHW] = out_ready;

  for (genvar i = 0; i < SHW; i++) begin : g_lvl
    localparam int K = SHW - 1 - i;
    localparam int S = 1 << K;

    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dsh;
    logic [SHW-1:0]   shin;
    logic [TAG_W-1:0] tin;
    logic             fin;
    logic             sin;
    logic             vin;
    logic             en;
    logic             lost;

    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   sh_q;
    logic [TAG_W-1:0] tag_q;
    logic             fill_q;
    logic             stk_q, stk_d;
    logic             v_q;

    if (i == 0) begin : g_head
      assign din  = in;
      assign shin = nshift;
      assign tin  = tag_in;
      assign fin  = arith & in[WIDTH-1];
      assign sin  = 1'b0;
      assign vin  = in_valid;
    end else begin : g_body
      assign din  = data_a[i-1];
      assign shin = sh_a[i-1];
      assign tin  = tag_a[i-1];
      assign fin  = fill_a[i-1];
      assign sin  = stk_a[i-1];
      assign vin  = v_a[i-1];
    end

    assign en = shin[K];

    // A level whose step reaches the full width flushes everything out
    if (S >= WIDTH) begin : g_flush
      assign dsh  = {WIDTH{fin}};
      assign lost = |din;
    end else begin : g_part
      assign dsh  = {{S{fin}}, din[WIDTH-1:S]};
      assign lost = |din[S-1:0];
    end

    assign data_d = en ? dsh : din;
    assign stk_d  = sin | (en & lost);
    assign rdy[i] = !v_q | rdy[i+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
        sh_q   <= '0;
        tag_q  <= '0;
        fill_q <= 1'b0;
        stk_q  <= 1'b0;
        v_q    <= 1'b0;
      end else if (rdy[i]) begin
        v_q <= vin;
        if (vin) begin
          data_q <= data_d;
          sh_q   <= shin;
          tag_q  <= tin;
          fill_q <= fin;
          stk_q  <= stk_d;
        end
      end
    end

    assign data_a[i] = data_q;
    assign sh_a[i]   = sh_q;
    assign tag_a[i]  = tag_q;
    assign fill_a[i] = fill_q;
    assign stk_a[i]  = stk_q;
    assign v_a[i]    = v_q;
  end

  assign in_ready  = rdy[0];
  assign out       = data_a[SHW-1];
  assign sticky    = stk_a[SHW-1];
  assign tag_out   = tag_a[SHW-1];
  assign out_valid = v_a[SHW-1];

  logic unused_tail;
  assign unused_tail = ^{sh_a[SHW-1], fill_a[SHW-1]};

endmodule

// File: doc/align_shift_pipe.md
# align_shift_pipe

Parametrised, pipelined right shifter for floating-point significand alignment and normalisation: the next generation of the 49-bit combinational shifter, with one register per shift level. It adds configurable width, logical or arithmetic fill, a sticky (OR-of-shifted-out-bits) output for round-to-nearest, a pass-through tag for exponent/sign, and a valid/ready handshake with per-stage backpressure. It sits between exponent-difference logic and the significand adder in the FP add path, and after the multiplier array in the FP multiply path.

## Interface
- WIDTH, 49: data width in bits; must be ≥ 2.
- TAG_W, 10: width of the side-band tag carried alongside the data.
- SHW, localparam = $clog2(WIDTH): shift-amount width; also the number of pipeline levels (LEVELS).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in  in  WIDTH  operand to shift.
- nshift  in  SHW  right-shift amount, 0 to 2^SHW−1.
- arith  in  1  0 = zero fill; 1 = fill with in[WIDTH−1].
- tag_in  in  TAG_W  side-band data, returned unchanged with the result.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- out  out  WIDTH  shifted result.
- sticky  out  1  OR of every bit shifted off the LSB end.
- tag_out  out  TAG_W  tag_in of the same beat.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.

## Operation
- Stage k (k = SHW−1 down to 0, MSB first) shifts right by 2^k when its copy of nshift[k] is 1; otherwise it passes data through.
- Fill bit is 0 when arith = 0. When arith = 1 it is the original in[WIDTH−1], captured at stage 0 and carried down the pipe.
- When 2^k ≥ WIDTH and the stage is enabled, its data output is all fill bits.
- Sticky per stage is the incoming sticky OR the OR of the low min(2^k, WIDTH) bits of the stage input when enabled. Stage-0 input sticky = 0.
- If nshift ≥ WIDTH: out = all fill bits, sticky = |in. This falls out of the stage chain; no separate comparator.
- If nshift = 0: out = in, sticky = 0.
- Each stage register holds data, the remaining nshift bits, fill, sticky, tag and a valid bit v[k].
- Handshake:
  - Stage k loads when ready[k] = !v[k] | ready[k+1]; ready after the last stage = out_ready.
  - in_ready = ready[first stage], which is combinational through the chain.
  - A beat is accepted when in_valid & in_ready.
  - A stage drops its beat when it passes it on and receives none; a bubble stage loads without waiting for downstream.
- out, sticky, tag_out and out_valid are driven from the last stage register. They must not change while out_valid & !out_ready.
- No state machine beyond the per-stage valid bits. No data is lost or reordered.

## Timing
- Latency: SHW cycles from accept to out_valid with no stalls (6 cycles at WIDTH = 49).
- Throughput: one beat per cycle while out_ready = 1.
- Reset: all v[k] = 0, out = 0, sticky = 0, tag_out = 0, out_valid = 0. in_ready = 1 in the first cycle after reset. Beats in flight at reset are discarded.
- Stall: with out_ready = 0 the pipe fills in at most SHW cycles, then in_ready = 0. When out_ready rises, in_ready = 1 in the same cycle.
- Simultaneous accept and output with a full pipe: allowed; occupancy stays the same.
- in_valid may drop without in_ready. When in_valid = 0, input values are don't-care.

## Test plan
- WIDTH = 49, in = 49'h1_0000_0000_0001, nshift = 1, arith = 0 → 6 cycles later: out = 49'h0_8000_0000_0000, sticky = 1, tag_out = tag_in.
- Same in, nshift = 48, arith = 0 → out = 49'h0_0000_0000_0001, sticky = 1. nshift = 49 → out = 0, sticky = 1. nshift = 63 → out = 0, sticky = 1.
- in = 49'h1_0000_0000_0000, arith = 1, nshift = 4 → out = 49'h1_F000_0000_0000, sticky = 0. nshift = 60 → out = all ones, sticky = 1.
- Back-to-back: 20 random beats with out_ready = 1 → results one per cycle, in order, each matching a reference model of in >> nshift with fill and sticky.
- Backpressure: hold out_ready = 0 with in_valid = 1 → exactly 6 beats accepted, in_ready = 0, out stable. Then toggle out_ready randomly → no loss, no duplication, order kept.
- Assert rst mid-stream with 4 beats in flight → next cycle out_valid = 0, out = 0, sticky = 0, in_ready = 1; no old beat ever appears at the output.
